// File: rtl/huffman_ctrl.sv
// huffman_ctrl: sequencing controller for an 8-symbol Huffman encoder
// Ports: clk/rst (async active-high); in_valid/in_weight weight beats for symbols 0..7;
//   busy high for the whole job; sort_character/sort_weight present the node table to an
//   external 8-wide sorter, sort_result returns node IDs smallest-first in the same cycle;
//   out_valid/out_char/out_code/out_len stream one (code, length) per symbol.
// Build option: HUFF_SAT_EN makes merged weights saturate at 31 instead of wrapping mod 32.
module huffman_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_weight,
  output logic        busy,
  output logic [31:0] sort_character,
  output logic [39:0] sort_weight,
  input  logic [31:0] sort_result,
  output logic        out_valid,
  output logic [3:0]  out_char,
  output logic [6:0]  out_code,
  output logic [2:0]  out_len
);
  typedef enum logic [1:0] {IDLE, LOAD, MERGE, OUT} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  nid_q, nid_d;
  logic [3:0]  id_q [8], id_d [8];
  logic [4:0]  w_q [8], w_d [8];
  logic [7:0]  mask_q [8], mask_d [8];
  logic [6:0]  code_q [8], code_d [8];
  logic [2:0]  len_q [8], len_d [8];
  logic        busy_q, busy_d, ov_q, ov_d;
  logic [3:0]  oc_q, oc_d;
  logic [6:0]  ocode_q, ocode_d;
  logic [2:0]  olen_q, olen_d;
  logic [2:0]  ea, eb;
  logic [5:0]  sum;
  logic [4:0]  merged;
  always_comb begin
    for (int e = 0; e < 8; e++) begin
      sort_character[4*e +: 4] = id_q[e];
      sort_weight[5*e +: 5] = w_q[e];
    end
  end
  always_comb begin
    ea = '0;
    eb = '0;
    for (int e = 0; e < 8; e++) begin
      if (id_q[e] == sort_result[3:0]) ea = 3'(e);
      if (id_q[e] == sort_result[7:4]) eb = 3'(e);
    end
    sum = {1'b0, w_q[ea]} + {1'b0, w_q[eb]};
`ifdef HUFF_SAT_EN
    merged = sum[5] ? 5'd31 : sum[4:0];
`else
    merged = sum[4:0];
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    nid_d = nid_q;
    id_d = id_q;
    w_d = w_q;
    mask_d = mask_q;
    code_d = code_q;
    len_d = len_q;
    busy_d = (state_q != IDLE) || in_valid;
    ov_d = 1'b0;
    oc_d = '0;
    ocode_d = '0;
    olen_d = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        id_d[0] = '0;
        w_d[0] = in_weight;
        mask_d[0] = 8'h01;
        code_d = '{default: '0};
        len_d = '{default: '0};
        cnt_d = 3'd1;
        state_d = LOAD;
      end
      LOAD: if (in_valid) begin
        id_d[cnt_q] = {1'b0, cnt_q};
        w_d[cnt_q] = in_weight;
        mask_d[cnt_q] = 8'h01 << cnt_q;
        cnt_d = cnt_q + 3'd1;
        nid_d = 4'd8;
        state_d = (cnt_q == 3'd7) ? MERGE : LOAD;
      end
      MERGE: begin
        // The smaller node's members get a 0 prepended (OR of nothing), the other's a 1.
        for (int s = 0; s < 8; s++)
          if (mask_q[ea][s] || mask_q[eb][s]) begin
            code_d[s] = code_q[s] | (7'(mask_q[eb][s]) << len_q[s]);
            len_d[s] = len_q[s] + 3'd1;
          end
        id_d[ea] = nid_q;
        w_d[ea] = merged;
        mask_d[ea] = mask_q[ea] | mask_q[eb];
        // ID 15 / weight 31 retires the entry: it can never sort ahead of a live node.
        id_d[eb] = 4'hf;
        w_d[eb] = 5'd31;
        mask_d[eb] = '0;
        nid_d = nid_q + 4'd1;
        cnt_d = (cnt_q == 3'd6) ? 3'd0 : cnt_q + 3'd1;
        state_d = (cnt_q == 3'd6) ? OUT : MERGE;
      end
      default: begin
        ov_d = 1'b1;
        oc_d = {1'b0, cnt_q};
        ocode_d = code_q[cnt_q];
        olen_d = len_q[cnt_q];
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? IDLE : OUT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nid_q <= '0;
      id_q <= '{default: 4'hf};
      w_q <= '{default: 5'd31};
      mask_q <= '{default: '0};
      code_q <= '{default: '0};
      len_q <= '{default: '0};
      busy_q <= 1'b0;
      ov_q <= 1'b0;
      oc_q <= '0;
      ocode_q <= '0;
      olen_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nid_q <= nid_d;
      id_q <= id_d;
      w_q <= w_d;
      mask_q <= mask_d;
      code_q <= code_d;
      len_q <= len_d;
      busy_q <= busy_d;
      ov_q <= ov_d;
      oc_q <= oc_d;
      ocode_q <= ocode_d;
      olen_q <= olen_d;
    end
  end
  assign busy = busy_q;
  assign out_valid = ov_q;
  assign out_char = oc_q;
  assign out_code = ocode_q;
  assign out_len = olen_q;
endmodule

// File: tb/tb_huffman_ctrl.sv
// tb_huffman_ctrl: self-checking bench for huffman_ctrl with an ideal sorter and a reference Huffman model
module tb_huffman_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_weight = '0;
  logic        busy, out_valid;
  logic [31:0] sort_character, sort_result;
  logic [39:0] sort_weight;
  logic [3:0]  out_char;
  logic [6:0]  out_code;
  logic [2:0]  out_len;
  int checks = 0;
  int errors = 0;

  huffman_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_weight(in_weight), .busy(busy),
    .sort_character(sort_character), .sort_weight(sort_weight), .sort_result(sort_result),
    .out_valid(out_valid), .out_char(out_char), .out_code(out_code), .out_len(out_len)
  );

  always #5 clk = ~clk;

  // Ideal sorter: rank every entry by (weight, id, position) and place its ID at that rank.
  function automatic logic [31:0] sorter(input logic [31:0] ch, input logic [39:0] wt);
    logic [31:0] r;
    int rank;
    r = '0;
    for (int e = 0; e < 8; e++) begin
      rank = 0;
      for (int f = 0; f < 8; f++)
        if ({wt[5*f +: 5], ch[4*f +: 4], 3'(f)} < {wt[5*e +: 5], ch[4*e +: 4], 3'(e)}) rank++;
      r[4*rank +: 4] = ch[4*e +: 4];
    end
    return r;
  endfunction

  assign sort_result = sorter(sort_character, sort_weight);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int w;
    int id;
    logic [7:0] m;
  } node_t;

  logic [55:0] m_code;
  logic [23:0] m_len;

  // Reference: greedy Huffman over a queue of nodes, prepending one bit per merge.
  task automatic model(input logic [39:0] wv);
    node_t q[$];
    node_t a, b, n;
    int cl[8], cv[8];
    int nid, mi;
    nid = 8;
    for (int k = 0; k < 8; k++) begin
      n.w = int'(wv[5*k +: 5]);
      n.id = k;
      n.m = 8'(1 << k);
      q.push_back(n);
      cl[k] = 0;
      cv[k] = 0;
    end
    repeat (7) begin
      mi = 0;
      for (int i = 1; i < q.size(); i++)
        if (q[i].w < q[mi].w || (q[i].w == q[mi].w && q[i].id < q[mi].id)) mi = i;
      a = q[mi];
      q.delete(mi);
      mi = 0;
      for (int i = 1; i < q.size(); i++)
        if (q[i].w < q[mi].w || (q[i].w == q[mi].w && q[i].id < q[mi].id)) mi = i;
      b = q[mi];
      q.delete(mi);
      for (int s = 0; s < 8; s++) begin
        if (a.m[s]) cl[s]++;
        if (b.m[s]) begin
          cv[s] += 1 << cl[s];
          cl[s]++;
        end
      end
`ifdef HUFF_SAT_EN
      n.w = (a.w + b.w > 31) ? 31 : a.w + b.w;
`else
      n.w = (a.w + b.w) % 32;
`endif
      n.id = nid++;
      n.m = a.m | b.m;
      q.push_back(n);
    end
    for (int k = 0; k < 8; k++) begin
      m_code[7*k +: 7] = 7'(cv[k]);
      m_len[3*k +: 3] = 3'(cl[k]);
    end
  endtask

  // Drive 8 beats with `gap` idle cycles between them; returns at the negedge after the last beat's edge.
  task automatic load(input logic [39:0] w, input int gap);
    for (int k = 0; k < 8; k++) begin
      if (k > 0)
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
          chk("busy_gap", busy, 1);
        end
      @(negedge clk);
      in_valid = 1'b1;
      in_weight = w[5*k +: 5];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [39:0] w, input logic [55:0] ec, input logic [23:0] el,
                         input int gap, input bit pm, input bit po, input string tag);
    int c;
    c = 0;
    load(w, gap);
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
      in_valid = pm && c == 3;
      in_weight = 5'd1;
    end
    in_valid = 1'b0;
    chk($sformatf("%s_latency", tag), c, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), out_valid, 1);
      chk($sformatf("%s_char%0d", tag, k), out_char, k);
      chk($sformatf("%s_code%0d", tag, k), out_code, ec[7*k +: 7]);
      chk($sformatf("%s_len%0d", tag, k), out_len, el[3*k +: 3]);
      in_valid = po && k == 2;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk($sformatf("%s_valid_end", tag), out_valid, 0);
    chk($sformatf("%s_busy_end", tag), busy, 0);
  endtask

  typedef struct packed {
    logic [39:0] w;
    logic [55:0] code;
    logic [23:0] len;
    logic [1:0]  gap;
    logic        pm;
    logic        po;
  } vec_t;

  vec_t tv [4];
  logic [55:0] c3, cch;
  logic [23:0] l3, lch;
  logic [39:0] w3, w31, wr;

  initial begin
    for (int k = 0; k < 8; k++) begin
      c3[7*k +: 7] = 7'(k);
      l3[3*k +: 3] = 3'd3;
      w3[5*k +: 5] = 5'd3;
      w31[5*k +: 5] = 5'd31;
      cch[7*k +: 7] = (k == 0) ? 7'd0 : 7'd1;
      lch[3*k +: 3] = (k < 2) ? 3'd7 : 3'(8 - k);
    end
`ifdef HUFF_SAT_EN
    cch = c3;
    lch = l3;
`endif
    tv[0] = '{w3, c3, l3, 2'd0, 1'b0, 1'b0};
    tv[1] = '{w31, cch, lch, 2'd0, 1'b0, 1'b0};
    tv[2] = '{w3, c3, l3, 2'd3, 1'b0, 1'b0};
    tv[3] = '{w3, c3, l3, 2'd0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_code", out_code, 0);
    chk("rst_len", out_len, 0);
    chk("rst_sort_char", sort_character, 32'hffff_ffff);
    chk("rst_sort_w", sort_weight, 40'hff_ffff_ffff);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_job(tv[i].w, tv[i].code, tv[i].len, int'(tv[i].gap), tv[i].pm, tv[i].po, $sformatf("vec%0d", i));

    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 8; k++) wr[5*k +: 5] = 5'($urandom_range(31));
      model(wr);
      run_job(wr, m_code, m_len, int'($urandom_range(1)), 1'b0, 1'b0, $sformatf("rand%0d", j));
    end

    load(w3, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_char", out_char, 0);
    chk("mid_rst_code", out_code, 0);
    chk("mid_rst_len", out_len, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stale;
      stale = 0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid || busy) stale++;
      end
      chk("stale_beats", stale, 0);
    end
    run_job(w3, c3, l3, 0, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_ctrl.md
# huffman_ctrl

- Sequencing controller for an 8-symbol Huffman encoder.
- Collects 8 symbol weights and drives an external combinational 8-wide sorter (`IP_WIDTH=8`) over the `sort_*` ports.
- Performs one greedy merge per cycle, 7 merges in total, building each symbol's code bottom-up, then streams 8 (code, length) results.
- Sits between the input sampler and the bitstream packer; the sorter is instantiated beside it and is shared with no other client while `busy` is high.

## Interface
- `SYMS`, 8: number of symbols; fixed at 8 (matches sorter width).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: one weight beat; beat k carries the weight of symbol k.
- `in_weight` input 5: symbol weight, 0..31.
- `busy` output 1: high from first accepted beat until the last output beat.
- `sort_character` output 32: node ID of table entry e, in bits [4e+3:4e].
- `sort_weight` output 40: weight of table entry e, in bits [5e+4:5e].
- `sort_result` input 32: sorter output, same cycle; slot 0 is the smallest node.
  - Ordering: ascending weight; ties go to the smaller ID first.
- `out_valid` output 1: result beat valid.
- `out_char` output 4: symbol index 0..7.
- `out_code` output 7: code right-aligned; bit [len-1] is the root-side bit.
- `out_len` output 3: code length, 1..7.

## Operation
- Internal table: 8 entries e, each holding `id` (4b), `w` (5b) and `mask` (8b symbol membership). Per symbol: `code` (7b) and `len` (3b).
- State IDLE:
  - On `in_valid`, write entry 0 = {id 0, w in_weight, mask 8'h01}, clear all codes and lengths, go to LOAD.
- State LOAD:
  - Each `in_valid` beat k writes entry k = {id k, w, mask 1<<k}.
  - Gaps (`in_valid` low) are allowed and do not advance the beat counter.
  - After beat 7, go to MERGE with round r=0 and next_id=8.
- State MERGE, one round per cycle:
  - `a` = ID at `sort_result` slot 0; `b` = ID at slot 1.
  - Find entries ea and eb by ID compare.
  - For every symbol in mask[ea]: code gets bit 0 at position len, then len+1.
  - For every symbol in mask[eb]: same, with bit 1.
  - ea <= {next_id, merged weight, mask[ea]|mask[eb]}.
  - eb <= {15, 31, 0}. ID 15 with weight 31 always sorts last.
  - next_id+1, r+1. After r=6, go to OUT.
- Merged weight = w[ea]+w[eb], handled per the Configuration section.
- `sort_character` and `sort_weight` always present the current table, in every state.
- State OUT:
  - 8 cycles; beat k drives out_valid=1, out_char=k, out_code=code[k], out_len=len[k].
  - Then return to IDLE.
- `in_valid` is ignored in MERGE and OUT.
- Reset values:
  - FSM is IDLE; busy, out_valid, out_char, out_code, out_len are all 0.
  - All table entries are {15, 31, 0}.
- Reset asserted in any state aborts the job; no partial output follows.

## Timing
- Last load beat at edge T:
  - Merges occur at edges T+1..T+7.
  - out_valid is high for cycles T+8..T+15.
  - busy falls after the T+15 beat.
- `busy` rises in the cycle after the first accepted beat.
- `in_valid` in the cycle after the last OUT beat (IDLE) starts a new job. A new job needs no idle gap.
- All outputs are registered. The sort path is combinational within one cycle.

## Configuration
- `HUFF_SAT_EN` defined: merged weight = min(w[ea]+w[eb], 31), saturating.
- `HUFF_SAT_EN` undefined: merged weight = (w[ea]+w[eb]) mod 32, wrapping.
- All other behaviour is identical in both builds.

## Test plan
- All weights 3, back-to-back beats:
  - Symbol k -> out_code=k, out_len=3, for k=0..7.
  - out_valid occurs exactly 8–15 cycles after the last beat.
- All weights 31, `HUFF_SAT_EN` defined:
  - Expected result is the same as the previous test (code k, len 3).
  - Checks that ties favour the lower ID.
- All weights 31, `HUFF_SAT_EN` undefined (wrap to 30, 29, ...), giving a chain:
  - Symbol 0 -> code 0000000, len 7.
  - Symbol 1 -> code 0000001, len 7.
  - Symbol k in 2..7 -> len 8-k, code 1.
- Load with 3-cycle `in_valid` gaps between beats, then the all-3 weights:
  - Same codes as the first test.
  - busy stays high across the gaps.
- Pulse `in_valid` during MERGE and during OUT:
  - Both are ignored; results are unchanged.
- Assert rst at the 4th MERGE cycle, then run a fresh all-3 job:
  - All outputs are 0 during reset.
  - No stale beats appear.
  - The fresh job produces correct codes.
